alu_instr_issue: RTL and testbench
==================================

// Module: alu_instr_issue
// PURPOSE
//  Upstream feeder for the ALU/register-file stage: accepts 16-bit instruction words over valid/ready,
//  buffers them in a small FIFO, decodes them, and issues at most one ALU op per cycle on the
//  functionCode/readReg1/readReg2/writeReg/countOp signals the ALU/register-file stage consumes.
//  Handles NOP, HALT and illegal words locally; only ALU ops reach the downstream stage.
// PARAMETERS
//  WORD_SIZE   16  instruction word width (fixed encoding below assumes 16)
//  FIFO_DEPTH  4   instruction buffer entries (power of 2, >=2)
// PORTS
//  clk           in   1   single clock; all state updates on posedge
//  reset_n       in   1   synchronous active-low reset
//  start         in   1   IDLE/HALTED -> RUN request
//  instr_in      in   16  instruction word
//  instr_valid   in   1   instr_in valid
//  instr_ready   out  1   FIFO can accept (count < FIFO_DEPTH)
//  issue_valid   out  1   outputs below carry a new ALU op this cycle
//  functionCode  out  3   ALU function (000 ADD,001 SUB,010 AND,011 ORR,100 NOT,101 TCP,110 SHL,111 SHR)
//  readReg1      out  2   source reg A
//  readReg2      out  2   source reg B (don't-care for NOT/TCP/SHL/SHR, still driven from rt)
//  writeReg      out  2   destination reg
//  countOp       out  8   issue sequence number of current op
//  illegal       out  1   one-cycle pulse: illegal opcode popped and dropped
//  halted        out  1   high while in HALTED
//  fifo_count    out  3   entries held, 0..FIFO_DEPTH
// BEHAVIOUR
//  Encoding: [15:13] opcode (000 ALU, 001 NOP, 111 HALT, others illegal); [12:11] rs; [10:9] rt;
//   [8:7] rd; [6:3] ignored; [2:0] funct -> functionCode.
//  Reset (reset_n=0 at posedge): state IDLE, FIFO empty, all outputs 0 (instr_ready then 1 next cycle).
//  Push: on posedge with instr_valid && instr_ready. instr_ready depends only on fifo_count, not on a
//   same-cycle pop: no push when full even if popping. Push allowed in IDLE, RUN, HALTED.
//  FSM: IDLE --start--> RUN; RUN --HALT popped--> HALTED; HALTED --start--> RUN. start in RUN ignored.
//  Pop: in RUN, one entry per posedge when fifo_count>0. No bypass: word pushed at edge E pops at
//   earliest E+1; its outputs are registered at that pop edge and visible the following cycle.
//  Simultaneous push+pop: fifo_count unchanged; pointers wrap modulo FIFO_DEPTH.
//  ALU pop: issue_valid=1 for one cycle, fields driven, countOp <= countOp+1 (first op carries 1;
//   8'hFF wraps to 8'h00).
//  NOP pop: issue_valid=0, countOp unchanged. Illegal pop: issue_valid=0, illegal=1 one cycle, countOp unchanged.
//  HALT pop: issue_valid=0, halted=1 from next cycle; remaining FIFO entries kept, not popped in HALTED.
//  When issue_valid=0, functionCode/readReg*/writeReg/countOp hold last issued values.
//  RUN with empty FIFO: issue_valid=0, stay RUN.
//  Reset mid-operation: FIFO contents discarded, countOp=0, any in-flight issue suppressed next cycle.
// TESTING
//  1 Reset, push 16'h0300 (ADD $2,$0,$1) and 16'h0107 (SHR $2,$0) in IDLE, pulse start -> two consecutive
//    issue_valid cycles: {fc=000,r1=0,r2=1,w=2,countOp=1} then {fc=111,r1=0,r2=0,w=2,countOp=2}.
//  2 In IDLE push 5 words back-to-back -> fifo_count=4, instr_ready=0, 5th word not accepted; start ->
//    instr_ready=1 cycle after first pop; exactly 4 words drained.
//  3 Stream 0x0300,0xE000,0x0107, start -> ADD issues, halted=1, fifo_count=1, no SHR issue for 10
//    cycles; pulse start -> SHR issues with countOp=2, halted=0.
//  4 Stream 0x2000 (NOP), 0x4000 (illegal), 0x0300 -> NOP: no issue; illegal one-cycle pulse; ADD issues
//    with countOp=1.
//  5 Issue 256 ALU ops -> countOp sequence 1..255, then 0x00 on 256th; no back-pressure gaps when
//    instr_valid held 1 (one issue per cycle steady state).
//  6 reset_n=0 for one edge while fifo_count=3 in RUN -> next cycle fifo_count=0, issue_valid=0,
//    countOp=0, halted=0, state IDLE (no issue until start).

Source files
------------

// File: rtl/alu_instr_issue.sv
// Instruction issue front-end: buffers 16-bit words, decodes them, and issues one ALU op per cycle.
// Latency: a word pushed at edge E pops at E+1; its decoded fields are visible the cycle after the pop.
// Backpressure: instr_ready drops only when the buffer is full; a same-cycle pop does not free a slot.
module alu_instr_issue #(
  parameter int WORD_SIZE  = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic                               start,
  input  logic [WORD_SIZE-1:0]               instr_in,
  input  logic                               instr_valid,
  output logic                               instr_ready,
  output logic                               issue_valid,
  output logic [2:0]                         functionCode,
  output logic [1:0]                         readReg1,
  output logic [1:0]                         readReg2,
  output logic [1:0]                         writeReg,
  output logic [7:0]                         countOp,
  output logic                               illegal,
  output logic                               halted,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  localparam logic [2:0] OP_ALU  = 3'b000;
  localparam logic [2:0] OP_NOP  = 3'b001;
  localparam logic [2:0] OP_HALT = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_HALTED = 2'd2
  } state_t;

  // Buffer entries keep only the decoded fields: {opcode, rs, rt, rd, funct}.
  logic [11:0]      r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             r_ready;
  state_t           r_state;

  logic             r_issue_vld;
  logic [2:0]       r_func;
  logic [1:0]       r_rs;
  logic [1:0]       r_rt;
  logic [1:0]       r_rd;
  logic [7:0]       r_count_op;
  logic             r_illegal;
  logic             r_halted;

  logic             w_push;
  logic             w_pop;
  logic [CNT_W-1:0] w_count_nxt;
  logic [11:0]      w_head;
  logic             w_unused;

  // Bits [6:3] of the instruction word carry no meaning in this encoding.
  assign w_unused = ^instr_in[6:3];

  assign w_push = instr_valid && r_ready;
  assign w_pop  = (r_state == S_RUN) && (r_count != '0);
  assign w_head = r_mem[r_rd_ptr];

  // Occupancy after this edge; push and pop together leave it unchanged.
  always_comb begin
    w_count_nxt = r_count;
    if (w_push && !w_pop) begin
      w_count_nxt = r_count + CNT_W'(1);
    end else if (w_pop && !w_push) begin
      w_count_nxt = r_count - CNT_W'(1);
    end
  end

  // Buffer storage; contents need no reset because occupancy is reset.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {instr_in[15:7], instr_in[2:0]};
    end
  end

  // Control FSM, buffer pointers and registered issue outputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_ready     <= 1'b0;
      r_issue_vld <= 1'b0;
      r_func      <= '0;
      r_rs        <= '0;
      r_rt        <= '0;
      r_rd        <= '0;
      r_count_op  <= '0;
      r_illegal   <= 1'b0;
      r_halted    <= 1'b0;
    end else begin
      r_issue_vld <= 1'b0;
      r_illegal   <= 1'b0;
      r_count     <= w_count_nxt;
      r_ready     <= (w_count_nxt < DEPTH_C);
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          if (w_pop) begin
            case (w_head[11:9])
              OP_ALU: begin
                r_issue_vld <= 1'b1;
                r_rs        <= w_head[8:7];
                r_rt        <= w_head[6:5];
                r_rd        <= w_head[4:3];
                r_func      <= w_head[2:0];
                r_count_op  <= r_count_op + 8'd1;
              end
              OP_NOP: begin
              end
              OP_HALT: begin
                r_state  <= S_HALTED;
                r_halted <= 1'b1;
              end
              default: begin
                r_illegal <= 1'b1;
              end
            endcase
          end
        end
        S_HALTED: begin
          if (start) begin
            r_state  <= S_RUN;
            r_halted <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign instr_ready  = r_ready;
  assign issue_valid  = r_issue_vld;
  assign functionCode = r_func;
  assign readReg1     = r_rs;
  assign readReg2     = r_rt;
  assign writeReg     = r_rd;
  assign countOp      = r_count_op;
  assign illegal      = r_illegal;
  assign halted       = r_halted;
  assign fifo_count   = r_count;

endmodule

// File: tb/tb_alu_instr_issue.sv
// Directed bench for alu_instr_issue: reset, issue ordering, full buffer, halt/resume,
// NOP/illegal handling, countOp wrap and mid-run reset, each with hand-computed expectations.
// Inputs driven and outputs sampled 1ns after the rising edge.
module tb_alu_instr_issue;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [15:0] instr_in;
  logic        instr_valid;
  logic        instr_ready;
  logic        issue_valid;
  logic [2:0]  functionCode;
  logic [1:0]  readReg1;
  logic [1:0]  readReg2;
  logic [1:0]  writeReg;
  logic [7:0]  countOp;
  logic        illegal;
  logic        halted;
  logic [2:0]  fifo_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_instr_issue #(.WORD_SIZE(16), .FIFO_DEPTH(4)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .start        (start),
    .instr_in     (instr_in),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .issue_valid  (issue_valid),
    .functionCode (functionCode),
    .readReg1     (readReg1),
    .readReg2     (readReg2),
    .writeReg     (writeReg),
    .countOp      (countOp),
    .illegal      (illegal),
    .halted       (halted),
    .fifo_count   (fifo_count)
  );

  // Issue bundle {issue_valid, fc, r1, r2, w, countOp}.
  function automatic logic [17:0] iss();
    return {issue_valid, functionCode, readReg1, readReg2, writeReg, countOp};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    start = 1'b0; instr_valid = 1'b0; instr_in = 16'h0000;
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic push(input logic [15:0] w);
    instr_in = w; instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    start = 1'b0; instr_valid = 1'b0; instr_in = 16'h0000;
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    checks++;
    if ({iss(), illegal, halted, fifo_count, instr_ready} !== 24'h0) begin
      errors++;
      $display("FAIL reset_outputs got %h exp 000000", {iss(), illegal, halted, fifo_count, instr_ready});
    end
    tick();
    checks++;
    if (instr_ready !== 1'b1) begin
      errors++; $display("FAIL reset_ready got %b exp 1", instr_ready);
    end
  endtask

  task automatic test_issue_order();
    logic [17:0] e1, e2;
    e1 = {1'b1, 3'b000, 2'd0, 2'd1, 2'd2, 8'd1};
    e2 = {1'b1, 3'b111, 2'd0, 2'd0, 2'd2, 8'd2};
    apply_reset();
    push(16'h0300);
    push(16'h0107);
    pulse_start();
    tick();
    checks++;
    if (iss() !== e1) begin errors++; $display("FAIL issue_add got %h exp %h", iss(), e1); end
    tick();
    checks++;
    if (iss() !== e2) begin errors++; $display("FAIL issue_shr got %h exp %h", iss(), e2); end
    tick();
    checks++;
    if (iss() !== {1'b0, e2[16:0]}) begin
      errors++; $display("FAIL issue_hold got %h exp %h", iss(), {1'b0, e2[16:0]});
    end
  endtask

  task automatic test_full();
    int n;
    apply_reset();
    instr_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      instr_in = 16'h0300 | 16'(i);
      tick();
    end
    instr_valid = 1'b0;
    checks++;
    if ({fifo_count, instr_ready} !== {3'd4, 1'b0}) begin
      errors++; $display("FAIL full_state got cnt=%0d rdy=%b exp cnt=4 rdy=0", fifo_count, instr_ready);
    end
    pulse_start();
    n = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (k == 0) begin
        checks++;
        if (instr_ready !== 1'b1) begin
          errors++; $display("FAIL full_ready_after_pop got %b exp 1", instr_ready);
        end
      end
      if (issue_valid === 1'b1) begin
        checks++;
        if (functionCode !== 3'(n)) begin
          errors++; $display("FAIL full_drain_order got fc=%0d exp %0d", functionCode, n);
        end
        n++;
      end
    end
    checks++;
    if (n != 4 || fifo_count !== 3'd0) begin
      errors++; $display("FAIL full_drain_count got %0d/cnt=%0d exp 4/cnt=0", n, fifo_count);
    end
  endtask

  task automatic test_halt();
    logic bad;
    logic [17:0] e_add, e_shr;
    e_add = {1'b1, 3'b000, 2'd0, 2'd1, 2'd2, 8'd1};
    e_shr = {1'b1, 3'b111, 2'd0, 2'd0, 2'd2, 8'd2};
    apply_reset();
    push(16'h0300);
    push(16'hE000);
    push(16'h0107);
    pulse_start();
    tick();
    checks++;
    if (iss() !== e_add) begin errors++; $display("FAIL halt_add got %h exp %h", iss(), e_add); end
    tick();
    checks++;
    if ({halted, fifo_count, issue_valid} !== {1'b1, 3'd1, 1'b0}) begin
      errors++;
      $display("FAIL halt_enter got h=%b cnt=%0d iv=%b exp h=1 cnt=1 iv=0", halted, fifo_count, issue_valid);
    end
    bad = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (issue_valid !== 1'b0 || halted !== 1'b1 || fifo_count !== 3'd1) bad = 1'b1;
    end
    checks++;
    if (bad) begin errors++; $display("FAIL halt_hold got activity while halted exp none"); end
    pulse_start();
    checks++;
    if ({halted, issue_valid} !== 2'b00) begin
      errors++; $display("FAIL halt_resume got h=%b iv=%b exp 0 0", halted, issue_valid);
    end
    tick();
    checks++;
    if (iss() !== e_shr) begin errors++; $display("FAIL halt_shr got %h exp %h", iss(), e_shr); end
  endtask

  task automatic test_nop_illegal();
    logic [17:0] e_add;
    e_add = {1'b1, 3'b000, 2'd0, 2'd1, 2'd2, 8'd1};
    apply_reset();
    push(16'h2000);
    push(16'h4000);
    push(16'h0300);
    pulse_start();
    tick();
    checks++;
    if ({issue_valid, illegal, countOp} !== {2'b00, 8'd0}) begin
      errors++; $display("FAIL nop_pop got iv=%b ill=%b cop=%0d exp 0 0 0", issue_valid, illegal, countOp);
    end
    tick();
    checks++;
    if ({issue_valid, illegal, countOp} !== {2'b01, 8'd0}) begin
      errors++; $display("FAIL illegal_pop got iv=%b ill=%b cop=%0d exp 0 1 0", issue_valid, illegal, countOp);
    end
    tick();
    checks++;
    if ({iss(), illegal} !== {e_add, 1'b0}) begin
      errors++; $display("FAIL post_illegal_add got %h ill=%b exp %h ill=0", iss(), illegal, e_add);
    end
  endtask

  task automatic test_count_wrap();
    apply_reset();
    pulse_start();
    instr_in = 16'h0300;
    instr_valid = 1'b1;
    for (int t = 1; t <= 257; t++) begin
      if (t == 257) instr_valid = 1'b0;
      tick();
      if (t >= 2) begin
        checks++;
        if ({issue_valid, countOp} !== {1'b1, 8'(t - 1)}) begin
          errors++;
          $display("FAIL wrap_seq t=%0d got iv=%b cop=%h exp iv=1 cop=%h", t, issue_valid, countOp, 8'(t - 1));
        end
      end
    end
    tick();
    checks++;
    if ({issue_valid, fifo_count, countOp} !== {1'b0, 3'd0, 8'h00}) begin
      errors++; $display("FAIL wrap_end got iv=%b cnt=%0d cop=%h exp 0 0 00", issue_valid, fifo_count, countOp);
    end
  endtask

  task automatic test_reset_mid();
    logic bad;
    apply_reset();
    instr_in = 16'h0300;
    instr_valid = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    instr_valid = 1'b0;
    pulse_start();
    tick();
    checks++;
    if ({fifo_count, issue_valid} !== {3'd3, 1'b1}) begin
      errors++; $display("FAIL mid_pre got cnt=%0d iv=%b exp 3 1", fifo_count, issue_valid);
    end
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    checks++;
    if ({fifo_count, issue_valid, countOp, halted} !== 13'h0) begin
      errors++;
      $display("FAIL mid_reset got cnt=%0d iv=%b cop=%0d h=%b exp all 0", fifo_count, issue_valid, countOp, halted);
    end
    tick();
    push(16'h0300);
    bad = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (issue_valid !== 1'b0 || fifo_count !== 3'd1) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++; $display("FAIL mid_idle got cnt=%0d iv=%b exp no pop in idle", fifo_count, issue_valid);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; start = 1'b0; instr_valid = 1'b0; instr_in = 16'h0000;
    test_reset();
    test_issue_order();
    test_full();
    test_halt();
    test_nop_illegal();
    test_count_wrap();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
